fetch_stage_f2: RTL and testbench

- Instruction-fetch stage that feeds the decode/control/register-file path: drives the PC, reads the asynchronous instruction memory and produces a registered IF/ID bundle (instruction, PC+4, valid) for decode.
- Replaces the bare PC + PC-adder + PC-source-mux trio for the pipelined phase. Adds backpressure, redirect/flush from the branch-resolution stage, and a halt state.

---
 rtl/fetch_stage_f2.sv | 115 +++++++++++
 tb/tb_fetch_stage_f2.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_f2.sv
// Pipelined instruction-fetch stage: PC register, async imem read, registered IF/ID bundle
// with backpressure, redirect/flush and halt. Define FETCH_PERF_EN for fetch/stall counters.
module fetch_stage_f2 #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HALT} state_e;

  state_e      state_q;
  logic [31:0] pc_q, instr_q, pc4_q;
  logic        valid_q, halted_q;

  logic [31:0] pc_plus4, redir_pc_d;
  logic        adv, is_halt, load_en, stall_ev;
  logic        unused_redir_lo;

  // PC is word aligned; the low redirect bits carry no information.
  assign redir_pc_d      = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lo = ^redirect_pc[1:0];

  assign pc_plus4 = pc_q + 32'd4;
  assign adv      = !valid_q || id_ready;
  assign is_halt  = (imem_data == HALT_WORD);
  assign load_en  = (state_q == S_FETCH) && !redirect && adv && !is_halt;
  assign stall_ev = (state_q == S_FETCH) && !redirect && !adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_BOOT;
      pc_q     <= {RESET_PC[31:2], 2'b00};
      valid_q  <= 1'b0;
      instr_q  <= 32'h0;
      pc4_q    <= 32'h0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          if (redirect) pc_q <= redir_pc_d;
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          // Redirect wins over stall; the flushed bundle keeps its payload but drops valid.
          if (redirect) begin
            pc_q    <= redir_pc_d;
            valid_q <= 1'b0;
          end else if (adv) begin
            if (is_halt) begin
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else begin
              instr_q <= imem_data;
              pc4_q   <= pc_plus4;
              pc_q    <= pc_plus4;
              valid_q <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (redirect) begin
            pc_q     <= redir_pc_d;
            halted_q <= 1'b0;
            state_q  <= S_FETCH;
          end
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign id_valid  = valid_q;
  assign id_instr  = instr_q;
  assign id_pc4    = pc4_q;
  assign halted    = halted_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (load_en)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_ev) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = load_en ^ stall_ev;
`endif

endmodule

// File: tb/tb_fetch_stage_f2.sv
// Bench for fetch_stage_f2: directed test-plan scenarios plus randomized traffic
// checked every cycle against a rule-level model of the fetch stage.
module tb_fetch_stage_f2;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rst_w = 1'b1;
  logic        redirect = 1'b0, id_ready = 1'b1;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr, imem_data, id_instr, id_pc4;
  logic        id_valid, halted;
  logic [31:0] w_addr, w_data, w_instr, w_pc4;
  logic        w_valid, w_halted;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count, w_fc, w_sc;
`endif

  logic [31:0] mem [256];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[9:2]];
  assign w_data    = mem[w_addr[9:2]];

  fetch_stage_f2 #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4), .halted(halted)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  fetch_stage_f2 #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst_w), .imem_addr(w_addr), .imem_data(w_data),
    .redirect(1'b0), .redirect_pc(32'h0), .id_ready(1'b1),
    .id_valid(w_valid), .id_instr(w_instr), .id_pc4(w_pc4), .halted(w_halted)
`ifdef FETCH_PERF_EN
    , .fetch_count(w_fc), .stall_count(w_sc)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: fetch behaviour written as plain rules over a PC and a bundle.
  logic        m_init = 1'b0, m_boot, m_halt, m_valid;
  logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_sc;

  always @(posedge clk) begin
    if (rst) begin
      m_init <= 1'b1; m_boot <= 1'b1; m_halt <= 1'b0; m_valid <= 1'b0;
      m_pc <= 32'h0; m_instr <= 32'h0; m_pc4 <= 32'h0; m_fc <= 32'h0; m_sc <= 32'h0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
      if (redirect) m_pc <= redirect_pc & ~32'h3;
    end else if (m_halt) begin
      if (redirect) begin m_halt <= 1'b0; m_pc <= redirect_pc & ~32'h3; end
    end else if (redirect) begin
      m_pc <= redirect_pc & ~32'h3; m_valid <= 1'b0;
    end else if (!m_valid || id_ready) begin
      if (mem[m_pc[9:2]] == HALT) begin
        m_valid <= 1'b0; m_halt <= 1'b1;
      end else begin
        m_instr <= mem[m_pc[9:2]]; m_pc4 <= m_pc + 32'd4; m_pc <= m_pc + 32'd4;
        m_valid <= 1'b1; m_fc <= m_fc + 32'd1;
      end
    end else begin
      m_sc <= m_sc + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
      chk("halted", {31'b0, halted}, {31'b0, m_halt});
      chk("id_instr", id_instr, m_instr);
      chk("id_pc4", id_pc4, m_pc4);
`ifdef FETCH_PERF_EN
      chk("fetch_count", fetch_count, m_fc);
      chk("stall_count", stall_count, m_sc);
`endif
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1300_0000 | i;
    mem[0] = 32'h2001_0005;

    // Reset / boot, with the wrap instance booting alongside.
    rst = 1'b1; rst_w = 1'b1; id_ready = 1'b1;
    step(); step();
    rst = 1'b0; rst_w = 1'b0;
    chk("boot_addr", imem_addr, 32'h0);
    chk("boot_valid", {31'b0, id_valid}, 32'h0);
    chk("boot_halted", {31'b0, halted}, 32'h0);
    chk("boot_instr", id_instr, 32'h0);
    step();
    chk("boot2_valid", {31'b0, id_valid}, 32'h0);
    chk("boot2_addr", imem_addr, 32'h0);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    step();
    chk("first_valid", {31'b0, id_valid}, 32'h1);
    chk("first_instr", id_instr, 32'h2001_0005);
    chk("first_pc4", id_pc4, 32'h4);
    chk("wrap_pc4", w_pc4, 32'h0);
    chk("wrap_addr1", w_addr, 32'h0);
    chk("wrap_valid", {31'b0, w_valid}, 32'h1);
    step();
    chk("bp_instr", id_instr, 32'h1300_0001);

    // Backpressure: bundle and PC hold for three stalled cycles.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", id_instr, 32'h1300_0001);
      chk("stall_pc4", id_pc4, 32'h8);
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_valid", {31'b0, id_valid}, 32'h1);
    end
    id_ready = 1'b1;
    step();
    chk("release_instr", id_instr, 32'h1300_0002);
    chk("release_pc4", id_pc4, 32'hC);

    // Redirect during a stall, unaligned target.
    id_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0042;
    step();
    chk("redir_valid", {31'b0, id_valid}, 32'h0);
    chk("redir_addr", imem_addr, 32'h40);
    redirect = 1'b0; id_ready = 1'b1;
    step();
    chk("redir_instr", id_instr, 32'h1300_0010);
    chk("redir_pc4", id_pc4, 32'h44);

    // Halt on mem[2], then redirect out of it.
    mem[2] = HALT; rst = 1'b1;
    step();
    rst = 1'b0;
    step(); step(); step();
    chk("pre_halt_pc4", id_pc4, 32'h8);
    step();
    for (int i = 0; i < 10; i++) begin
      chk("halt_flag", {31'b0, halted}, 32'h1);
      chk("halt_valid", {31'b0, id_valid}, 32'h0);
      chk("halt_addr", imem_addr, 32'h8);
      step();
    end
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    chk("unhalt_flag", {31'b0, halted}, 32'h0);
    chk("unhalt_addr", imem_addr, 32'h10);
    step();
    chk("unhalt_valid", {31'b0, id_valid}, 32'h1);
    chk("unhalt_pc4", id_pc4, 32'h14);

    // Counter scenario: 5 fetches, 3 stalls, 1 redirect.
    mem[2] = 32'h1300_0002; rst = 1'b1;
    step();
    rst = 1'b0;
    step(); step(); step(); step();
    id_ready = 1'b0;
    step(); step(); step();
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0; id_ready = 1'b1;
    step(); step();
    chk("perf_pc4", id_pc4, 32'h18);
`ifdef FETCH_PERF_EN
    chk("perf_fetch", fetch_count, 32'd5);
    chk("perf_stall", stall_count, 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("perf_fetch_rst", fetch_count, 32'd0);
    chk("perf_stall_rst", stall_count, 32'd0);
`endif

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(11) == 0) ? HALT : $urandom;
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(199) == 0);
      id_ready    = ($urandom_range(3) != 0);
      redirect    = ($urandom_range(9) == 0);
      redirect_pc = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
